// File: rtl/adc_pkg.sv
// Shared definitions for the multi-channel ADC capture front end:
// sequencer state encodings, the averaging-factor limit and the
// accumulator width helper.
package adc_pkg;

  // Sequencer states
  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_WAKE = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // Largest supported log2 of the decimation factor
  localparam int AVG_LOG2_MAX = 6;

  // Accumulator width: holding 2**avg_log2 full-scale samples needs
  // avg_log2 extra bits above the converter width.
  function automatic int acc_width(input int data_w, input int avg_log2);
    return data_w + avg_log2;
  endfunction

endpackage

// File: rtl/adc_ch_avg.sv
// Per-channel boxcar averager: accumulates registered samples while the
// sequencer runs, produces the truncated mean on the wrap sample, and
// keeps the sticky out-of-range flag for its channel.
module adc_ch_avg
  import adc_pkg::*;
#(
  parameter int DATA_W   = 14,
  parameter int AVG_LOG2 = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              run_i,       // sequencer in RUN and EN high
  input  logic              last_i,      // this sample closes the average
  input  logic              flag_clr_i,
  input  logic [DATA_W-1:0] d_i,
  input  logic              otr_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ovr_o
);

  localparam int ACC_W = acc_width(DATA_W, AVG_LOG2);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] sum_s;
  logic             ovr_q;
  logic             ovr_d;

  // Running sum including the current sample; cannot overflow ACC_W
  assign sum_s    = acc_q + ACC_W'(d_i);
  assign result_o = DATA_W'(sum_s >> AVG_LOG2);
  assign ovr_o    = ovr_q;

  // Accumulator next state: clear outside RUN, reload on wrap, else add
  always_comb begin
    acc_d = acc_q;
    if (!run_i) begin
      acc_d = {ACC_W{1'b0}};
    end else if (last_i) begin
      acc_d = {ACC_W{1'b0}};
    end else begin
      acc_d = sum_s;
    end
  end

  // Sticky overrange: a set in the same cycle as a clear wins
  always_comb begin
    ovr_d = ovr_q;
    if (run_i && otr_i) begin
      ovr_d = 1'b1;
    end else if (flag_clr_i) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Channel state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= {ACC_W{1'b0}};
      ovr_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovr_q <= ovr_d;
    end
  end

endmodule

// File: rtl/adc_capture_multi.sv
// Multi-channel ADC capture front end: power-up sequencer, input
// registers, shared decimation counter, per-channel averagers and a
// valid/ready output register with sticky overflow flag.
// Optional: define ADC_TWOS_COMP_EN to emit two's complement samples
// (MSB of each averaged channel inverted); otherwise offset-binary.
module adc_capture_multi
  import adc_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 14,
  parameter int AVG_LOG2 = 0,
  parameter int WAKE_CYC = 64
) (
  input  logic                     ADC_CLK,
  input  logic                     ADC_RST_N,
  output logic [NUM_CH-1:0]        ADC_CLK_OUT,
  input  logic [NUM_CH*DATA_W-1:0] ADC_D,
  input  logic [NUM_CH-1:0]        ADC_OTR,
  output logic [NUM_CH-1:0]        ADC_OE_N,
  output logic                     ADC_PWDN,
  input  logic                     EN,
  output logic [NUM_CH*DATA_W-1:0] SMP_DATA,
  output logic                     SMP_VALID,
  input  logic                     SMP_READY,
  output logic [NUM_CH-1:0]        OVR_STICKY,
  output logic                     OVF_STICKY,
  input  logic                     FLAG_CLR,
  output logic                     RUNNING
);

  localparam int DEC_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'((1 << AVG_LOG2) - 1);
  localparam int WK_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam logic [WK_W-1:0] WK_LAST = WK_W'(WAKE_CYC - 1);
`ifdef ADC_TWOS_COMP_EN
  localparam logic [DATA_W-1:0] SIGN_FLIP = {1'b1, {(DATA_W-1){1'b0}}};
`else
  localparam logic [DATA_W-1:0] SIGN_FLIP = {DATA_W{1'b0}};
`endif

  logic [NUM_CH*DATA_W-1:0] d_q;
  logic [NUM_CH-1:0]        otr_q;
  logic [1:0]               state_q, state_d;
  logic [WK_W-1:0]          wk_q, wk_d;
  logic [DEC_W-1:0]         dec_q, dec_d;
  logic [NUM_CH*DATA_W-1:0] data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     ovf_q, ovf_d;
  logic                     pwdn_q;
  logic [NUM_CH-1:0]        oe_n_q;
  logic                     running_q;
  logic                     run_s;
  logic                     wrap_s;
  logic                     hs_s;
  logic [NUM_CH*DATA_W-1:0] res_s;

  // Converter clocks are forwarded straight from the sample clock
  assign ADC_CLK_OUT = {NUM_CH{ADC_CLK}};

  assign run_s  = EN && (state_q == ST_RUN);
  assign wrap_s = run_s && (dec_q == DEC_LAST);
  assign hs_s   = valid_q && SMP_READY;

  assign ADC_PWDN   = pwdn_q;
  assign ADC_OE_N   = oe_n_q;
  assign RUNNING    = running_q;
  assign SMP_DATA   = data_q;
  assign SMP_VALID  = valid_q;
  assign OVF_STICKY = ovf_q;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [DATA_W-1:0] avg_s;

    adc_ch_avg #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
      .clk_i      (ADC_CLK),
      .rst_ni     (ADC_RST_N),
      .run_i      (run_s),
      .last_i     (wrap_s),
      .flag_clr_i (FLAG_CLR),
      .d_i        (d_q[ch*DATA_W +: DATA_W]),
      .otr_i      (otr_q[ch]),
      .result_o   (avg_s),
      .ovr_o      (OVR_STICKY[ch])
    );

    assign res_s[ch*DATA_W +: DATA_W] = avg_s ^ SIGN_FLIP;
  end

  // Sequencer: EN low forces OFF from any state; WAKE lasts WAKE_CYC cycles
  always_comb begin
    state_d = state_q;
    wk_d    = wk_q;
    if (!EN) begin
      state_d = ST_OFF;
      wk_d    = {WK_W{1'b0}};
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_WAKE;
          wk_d    = {WK_W{1'b0}};
        end
        ST_WAKE: begin
          if (wk_q == WK_LAST) begin
            state_d = ST_RUN;
          end else begin
            wk_d = wk_q + WK_W'(1);
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_OFF;
          wk_d    = {WK_W{1'b0}};
        end
      endcase
    end
  end

  // Decimation counter shared by all channels; restarts whenever RUN is left
  always_comb begin
    dec_d = dec_q;
    if (!run_s) begin
      dec_d = {DEC_W{1'b0}};
    end else if (wrap_s) begin
      dec_d = {DEC_W{1'b0}};
    end else begin
      dec_d = dec_q + DEC_W'(1);
    end
  end

  // Output register: load on free slot or same-cycle handshake, else drop
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (wrap_s) begin
      if (!valid_q || hs_s) begin
        data_d  = res_s;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (hs_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (FLAG_CLR && !(wrap_s && valid_q && !hs_s)) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_d;
    end
  end

  // All state and pin registers; converters powered down out of reset
  always_ff @(posedge ADC_CLK or negedge ADC_RST_N) begin
    if (!ADC_RST_N) begin
      d_q       <= {(NUM_CH*DATA_W){1'b0}};
      otr_q     <= {NUM_CH{1'b0}};
      state_q   <= ST_OFF;
      wk_q      <= {WK_W{1'b0}};
      dec_q     <= {DEC_W{1'b0}};
      data_q    <= {(NUM_CH*DATA_W){1'b0}};
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      pwdn_q    <= 1'b1;
      oe_n_q    <= {NUM_CH{1'b1}};
      running_q <= 1'b0;
    end else begin
      d_q       <= ADC_D;
      otr_q     <= ADC_OTR;
      state_q   <= state_d;
      wk_q      <= wk_d;
      dec_q     <= dec_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      pwdn_q    <= (state_d == ST_OFF);
      oe_n_q    <= {NUM_CH{state_d == ST_OFF}};
      running_q <= (state_d == ST_RUN);
    end
  end

endmodule

// File: tb/tb_adc_capture_multi.sv
// Directed self-checking bench for adc_capture_multi with two channels,
// 14-bit data, averaging by 4 and a 4-cycle wake period.
module tb_adc_capture_multi;

  localparam int NUM_CH   = 2;
  localparam int DATA_W   = 14;
  localparam int AVG_LOG2 = 2;
  localparam int WAKE_CYC = 4;
`ifdef ADC_TWOS_COMP_EN
  localparam logic [13:0] FLIP = 14'h2000;
`else
  localparam logic [13:0] FLIP = 14'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  clk_out;
  logic [27:0] adc_d;
  logic [1:0]  adc_otr;
  logic [1:0]  oe_n;
  logic        pwdn;
  logic        en;
  logic [27:0] smp_data;
  logic        smp_valid;
  logic        smp_ready;
  logic [1:0]  ovr;
  logic        ovf;
  logic        flag_clr;
  logic        running;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_capture_multi #(
    .NUM_CH   (NUM_CH),
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2),
    .WAKE_CYC (WAKE_CYC)
  ) dut (
    .ADC_CLK     (clk),
    .ADC_RST_N   (rst_n),
    .ADC_CLK_OUT (clk_out),
    .ADC_D       (adc_d),
    .ADC_OTR     (adc_otr),
    .ADC_OE_N    (oe_n),
    .ADC_PWDN    (pwdn),
    .EN          (en),
    .SMP_DATA    (smp_data),
    .SMP_VALID   (smp_valid),
    .SMP_READY   (smp_ready),
    .OVR_STICKY  (ovr),
    .OVF_STICKY  (ovf),
    .FLAG_CLR    (flag_clr),
    .RUNNING     (running)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [13:0] c0, input logic [13:0] c1);
    adc_d = {c1, c0};
    tick();
  endtask

  function automatic logic [27:0] smp(input logic [13:0] c0, input logic [13:0] c1);
    return {c1 ^ FLIP, c0 ^ FLIP};
  endfunction

  // Raise EN and step through the wake window; the caller feeds the first
  // RUN sample next so it lands in the input register as RUN begins.
  task automatic start_run(input bit otr_pulse);
    en = 1'b1;
    tick();
    check_eq("pwdn_after_en", pwdn, 1'b0);
    check_eq("oe_after_en", oe_n, 2'b00);
    check_eq("running_wake0", running, 1'b0);
    if (otr_pulse) adc_otr = 2'b10;
    for (int i = 0; i < WAKE_CYC - 1; i++) begin
      tick();
      adc_otr = 2'b00;
      check_eq("valid_in_wake", smp_valid, 1'b0);
      check_eq("running_in_wake", running, 1'b0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    smp_ready = 1'b1;
    flag_clr  = 1'b0;
    adc_otr   = 2'b00;
    adc_d     = {14'd5, 14'd1000};
    tick();
    tick();
    check_eq("rst_pwdn", pwdn, 1'b1);
    check_eq("rst_oe_n", oe_n, 2'b11);
    check_eq("rst_valid", smp_valid, 1'b0);
    check_eq("rst_data", smp_data, 28'd0);
    check_eq("rst_ovr", ovr, 2'b00);
    check_eq("rst_ovf", ovf, 1'b0);
    check_eq("rst_running", running, 1'b0);
    rst_n = 1'b1;
    tick();
    check_eq("off_pwdn", pwdn, 1'b1);

    // Wake with an OTR pulse that must be ignored
    start_run(1'b1);

    // Group A: ch0 10,20,30,40 -> 25; ch1 full scale -> 16383
    feed(14'd10, 14'd16383);
    check_eq("running_run", running, 1'b1);
    feed(14'd20, 14'd16383);
    feed(14'd30, 14'd16383);
    feed(14'd40, 14'd16383);
    check_eq("valid_before_wrap", smp_valid, 1'b0);

    // Group B with downstream stalled: A held, B dropped
    smp_ready = 1'b0;
    feed(14'd100, 14'd100);
    check_eq("a_valid", smp_valid, 1'b1);
    check_eq("a_data", smp_data, smp(14'd25, 14'd16383));
    check_eq("a_ovf", ovf, 1'b0);
    feed(14'd100, 14'd100);
    feed(14'd100, 14'd100);
    feed(14'd100, 14'd100);
    check_eq("a_held", smp_data, smp(14'd25, 14'd16383));

    // Group C: ch0 zero, ch1 midscale
    feed(14'd0, 14'd8192);
    check_eq("stall_valid", smp_valid, 1'b1);
    check_eq("stall_data", smp_data, smp(14'd25, 14'd16383));
    check_eq("stall_ovf", ovf, 1'b1);
    smp_ready = 1'b1;
    feed(14'd0, 14'd8192);
    check_eq("hs_valid_drop", smp_valid, 1'b0);
    flag_clr = 1'b1;
    feed(14'd0, 14'd8192);
    flag_clr = 1'b0;
    check_eq("ovf_cleared", ovf, 1'b0);
    check_eq("ovr_wake_ignored", ovr, 2'b00);
    feed(14'd0, 14'd8192);

    // Group D: truncation 10/4 -> 2, 65531/4 -> 16382; OTR on ch1 in RUN
    feed(14'd1, 14'd16383);
    check_eq("c_valid", smp_valid, 1'b1);
    check_eq("c_data", smp_data, smp(14'd0, 14'd8192));
    adc_otr = 2'b10;
    feed(14'd2, 14'd16383);
    adc_otr = 2'b00;
    feed(14'd3, 14'd16383);
    feed(14'd4, 14'd16382);
    check_eq("ovr_run_set", ovr, 2'b10);

    // Group E: clear/set collision, then EN drop mid-average
    adc_otr = 2'b01;
    feed(14'd1000, 14'd0);
    check_eq("d_valid", smp_valid, 1'b1);
    check_eq("d_data", smp_data, smp(14'd2, 14'd16382));
    check_eq("ovr_held", ovr, 2'b10);
    adc_otr  = 2'b00;
    flag_clr = 1'b1;
    feed(14'd1000, 14'd0);
    check_eq("ovr_set_wins", ovr, 2'b01);
    en = 1'b0;
    feed(14'd1000, 14'd0);
    flag_clr = 1'b0;
    check_eq("ovr_clr", ovr, 2'b00);
    check_eq("off_pwdn_again", pwdn, 1'b1);
    check_eq("off_oe_again", oe_n, 2'b11);
    check_eq("off_running", running, 1'b0);
    check_eq("off_valid", smp_valid, 1'b0);

    // Re-wake; the partial sum of group E must be gone
    start_run(1'b0);
    feed(14'd4, 14'd100);
    feed(14'd8, 14'd100);
    feed(14'd12, 14'd100);
    feed(14'd16, 14'd100);
    feed(14'd0, 14'd0);
    check_eq("f_valid", smp_valid, 1'b1);
    check_eq("f_data", smp_data, smp(14'd10, 14'd100));
    check_eq("f_running", running, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
